// File: rtl/blink_pkg.sv
// Types and default constants shared by the blink generator and the blink period monitor.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCK
  } state_t;

  localparam int EXP_HALF_DEF = 11;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/blink_period_monitor_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, followed by a history flop.
// Produces a one-cycle strobe on either polarity of transition.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_edge
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sig_edge = sync2 ^ prev;

endmodule

// File: rtl/blink_period_monitor.sv
// Measures edge-to-edge intervals of an asynchronous blink input and locks once
// LOCK_N consecutive intervals land within TOL of EXP_HALF.
module blink_period_monitor
  import blink_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int EXP_HALF = EXP_HALF_DEF,
  parameter int TOL      = 1,
  parameter int LOCK_N   = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clr_lost,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic             timeout
);

  localparam int MC_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]        IVL_MAX   = '1;
  localparam logic [CNT_W-1:0]        TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]        EXP_CMP   = CNT_W'(EXP_HALF);
  localparam logic signed [CNT_W:0]   TOL_S     = (CNT_W + 1)'(TOL);
  localparam logic [MC_W-1:0]         LOCK_LAST = MC_W'(LOCK_N - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == IVL_MAX) ? v : v + 1'b1;
  endfunction

  // One extra bit keeps the difference exact for any measurement, saturated or not.
  function automatic logic in_tol(input logic [CNT_W-1:0] m);
    logic signed [CNT_W:0] d;
    d = $signed({1'b0, m}) - $signed({1'b0, EXP_CMP});
    if (d[CNT_W]) d = -d;
    return d <= TOL_S;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] ivl;
  logic [CNT_W-1:0] meas;
  logic [MC_W-1:0]  match_cnt;
  logic             sig_edge;
  logic             match;
  logic             to_hit;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .sig_edge (sig_edge)
  );

  assign meas   = sat_inc(ivl);
  assign match  = in_tol(meas);
  assign to_hit = (state != IDLE) && !sig_edge && (ivl == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ivl          <= '0;
      match_cnt    <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      ivl          <= sig_edge ? '0 : sat_inc(ivl);
      // Any lost-set below overrides this clear in the same cycle.
      if (clr_lost) lost <= 1'b0;
      case (state)
        IDLE: begin
          if (sig_edge) state <= ACQ;
        end
        ACQ: begin
          if (sig_edge) begin
            half_period  <= meas;
            period_valid <= 1'b1;
            if (match) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == LOCK_LAST) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end else if (to_hit) begin
            timeout   <= 1'b1;
            state     <= IDLE;
            match_cnt <= '0;
          end
        end
        LOCK: begin
          if (sig_edge) begin
            half_period  <= meas;
            period_valid <= 1'b1;
            if (!match) begin
              state     <= ACQ;
              locked    <= 1'b0;
              lost      <= 1'b1;
              match_cnt <= '0;
            end
          end else if (to_hit) begin
            timeout   <= 1'b1;
            state     <= IDLE;
            match_cnt <= '0;
            locked    <= 1'b0;
            lost      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
